// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the Wishbone GPIO master.
//   - wb_state_e   : controller FSM states (IDLE / BUS / RESP)
//   - rsp_status_e : 2-bit response status codes returned on rsp_status_o
//   - default address/data widths and timeout length
package wb_gpio_pkg;

  localparam int unsigned WB_AW_DEF      = 8;
  localparam int unsigned WB_DW_DEF      = 32;
  localparam int unsigned WB_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_ERR     = 2'b01,
    RSP_TIMEOUT = 2'b10
  } rsp_status_e;

endpackage

// File: rtl/wb_gpio_timeout.sv
// Bus-cycle watchdog for wb_gpio_master.
//   clk_i     : clock, rising edge
//   rst_ni    : synchronous active-low reset
//   clear_i   : restart the count (asserted when a bus cycle is launched)
//   enable_i  : one bus cycle elapsed without ack/err
//   expired_o : this waiting cycle is the TIMEOUT_CYCLES-th one; end the
//               bus cycle at the coming edge
module wb_gpio_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count reaches TIMEOUT_CYCLES at the edge that ends the cycle, so
  // the bus stays up for exactly TIMEOUT_CYCLES unanswered cycles.
  assign expired_o = enable_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/wb_gpio_master.sv
// Wishbone classic-cycle master driven by a simple command/response port.
//
// Optional feature: define WB_GPIO_MASTER_TIMEOUT_EN to abort bus cycles
// that receive no ack/err within TIMEOUT_CYCLES cycles (status TIMEOUT).
// Without it the master waits indefinitely for the slave.
//
// Ports
//   wb_clk_i, wb_rst_i       : clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o  : command handshake; cmd_we_i, cmd_adr_i,
//                              cmd_dat_i, cmd_sel_i carry the request
//   rsp_valid_o/rsp_ready_i  : response handshake; rsp_dat_o, rsp_status_o
//   wb_cyc_o .. wb_sel_o     : Wishbone master outputs
//   wb_dat_i, wb_ack_i, wb_err_i : Wishbone slave response
//   wb_inta_i, irq_o, irq_rise_o : interrupt input, registered copy, rise pulse
//   dbg_state_o              : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. cmd_ready_o is 1 only in IDLE; the response is held unchanged in
// RESP until rsp_ready_i, and a new command is taken no earlier than the
// cycle after the response is consumed.
module wb_gpio_master
  import wb_gpio_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_DEF,
  parameter int unsigned AW             = WB_AW_DEF,
  parameter int unsigned DW             = WB_DW_DEF
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic [1:0]      rsp_status_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_inta_i,
  output logic            irq_o,
  output logic            irq_rise_o,
  output wb_state_e       dbg_state_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_gpio_master: TIMEOUT_CYCLES must be within 1..255");
  end

  wb_state_e       state_q, state_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
  logic [1:0]      rsp_status_q, rsp_status_d;
  logic            irq_q, irq_d;

  logic cmd_fire;
  logic in_bus;
  logic bus_ack;
  logic bus_err;
  logic to_hit;
  logic bus_end;

  assign in_bus   = (state_q == ST_BUS);
  assign cmd_fire = cmd_valid_i && cmd_ready_o;
  // Slave responses only matter while a cycle is in flight.
  assign bus_ack  = in_bus && wb_ack_i;
  assign bus_err  = in_bus && wb_err_i;
  assign bus_end  = bus_ack || bus_err || to_hit;

`ifdef WB_GPIO_MASTER_TIMEOUT_EN
  wb_gpio_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_i),
    .clear_i   (cmd_fire),
    .enable_i  (in_bus && !wb_ack_i && !wb_err_i),
    .expired_o (to_hit)
  );
`else
  assign to_hit = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_fire)    state_d = ST_BUS;
      ST_BUS:  if (bus_end)     state_d = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // cmd_ready_o is held low while reset is asserted so no command can be
  // offered before reset is released.
  always_comb begin
    cmd_ready_o = (state_q == ST_IDLE) && wb_rst_i;
    dbg_state_o = state_q;
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    irq_d        = wb_inta_i;

    // Bus fields are only loaded here, so they cannot move while cyc is up.
    if (cmd_fire) begin
      cyc_d = 1'b1;
      we_d  = cmd_we_i;
      adr_d = cmd_adr_i;
      dat_d = cmd_dat_i;
      sel_d = cmd_sel_i;
    end

    if (in_bus && bus_end) begin
      cyc_d       = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_dat_d   = '0;
      if (bus_err) begin
        rsp_status_d = RSP_ERR;
      end else if (bus_ack) begin
        rsp_status_d = RSP_OK;
        if (!we_q) begin
          rsp_dat_d = wb_dat_i;
        end
      end else begin
        rsp_status_d = RSP_TIMEOUT;
      end
    end

    if ((state_q == ST_RESP) && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= RSP_OK;
      irq_q        <= 1'b0;
    end else begin
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      irq_q        <= irq_d;
    end
  end

  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_sel_o     = sel_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign irq_o        = irq_q;
  // Rise pulse is combinational from the live input; forced low in reset,
  // where irq_q is cleared and would otherwise expose a spurious edge.
  assign irq_rise_o   = wb_inta_i && !irq_q && wb_rst_i;

endmodule

// File: tb/tb_wb_gpio_master.sv
module tb_wb_gpio_master;
  import wb_gpio_pkg::*;

  localparam int TO_CYC = 16;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [7:0]  cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_status_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_inta_i = 1'b0;
  logic        irq_o, irq_rise_o;
  wb_state_e   dbg_state;

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];   // {status, data}

  typedef struct {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          waits;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic [1:0]  exp_st;
    logic [31:0] exp_dat;
  } vec_t;
  vec_t vecs[7];

  wb_gpio_master #(.TIMEOUT_CYCLES(TO_CYC), .AW(8), .DW(32)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_status_o(rsp_status_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_inta_i(wb_inta_i), .irq_o(irq_o), .irq_rise_o(irq_rise_o),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer a command, wait (bounded) for the handshake, queue its expected response.
  task automatic send_cmd(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [1:0] exp_st,
                          input logic [31:0] exp_dat, input bit push);
    int n = 0;
    cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
    cmd_valid_i = 1'b1;
    while (!cmd_ready_o && n < 50) begin tick(); n++; end
    check("cmd_ready_wait", cmd_ready_o, 1);
    tick();
    cmd_valid_i = 1'b0;
    if (push) exp_q.push_back({exp_st, exp_dat});
    check("cyc_stb_after_hs", {wb_cyc_o, wb_stb_o}, 2'b11);
  endtask

  // Slave: hold off `waits` cycles checking bus stability, then answer.
  task automatic bus_respond(input int waits, input logic ack, input logic err,
                             input logic [31:0] rdata, input logic we, input logic [7:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel);
    for (int i = 0; i <= waits; i++) begin
      check("wb_hold", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o},
            {2'b11, we, adr, dat, sel});
      if (i == waits) begin
        wb_ack_i = ack; wb_err_i = err; wb_dat_i = rdata;
      end
      tick();
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    check("rsp_latency", {rsp_valid_o, wb_cyc_o}, 2'b10);
  endtask

  // Pop expected response, compare, consume it.
  task automatic collect_rsp();
    int n = 0;
    logic [33:0] exp;
    while (!rsp_valid_o && n < 300) begin tick(); n++; end
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL rsp_unexpected: got %h expected none", {rsp_status_o, rsp_dat_o});
    end else begin
      exp = exp_q.pop_front();
      check("rsp_valid", rsp_valid_o, 1);
      check("rsp_status_data", {rsp_status_o, rsp_dat_o}, exp);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("rsp_drain", {rsp_valid_o, cmd_ready_o, wb_cyc_o}, 3'b010);
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{1'b1, 8'h04, 32'hA5A5_0F0F, 4'hF, 2, 1'b1, 1'b0, 32'h0,         RSP_OK,  32'h0};
    vecs[1] = '{1'b0, 8'h00, 32'h0,         4'hF, 0, 1'b1, 1'b0, 32'h1234_5678, RSP_OK,  32'h1234_5678};
    vecs[2] = '{1'b0, 8'h08, 32'h0,         4'hF, 1, 1'b0, 1'b1, 32'hDEAD_BEEF, RSP_ERR, 32'h0};
    vecs[3] = '{1'b0, 8'h0C, 32'h0,         4'h1, 0, 1'b1, 1'b1, 32'h0000_55AA, RSP_ERR, 32'h0};
    vecs[4] = '{1'b1, 8'hFC, 32'hFFFF_FFFF, 4'hC, 3, 1'b0, 1'b1, 32'h0,         RSP_ERR, 32'h0};
    vecs[5] = '{1'b0, 8'h10, 32'h0,         4'hF, 4, 1'b1, 1'b0, 32'hFFFF_FFFF, RSP_OK,  32'hFFFF_FFFF};
    vecs[6] = '{1'b1, 8'h20, 32'h0000_CAFE, 4'h3, 0, 1'b1, 1'b0, 32'h1111_2222, RSP_OK,  32'h0};

    // Reset state, with busy inputs asserted during reset.
    cmd_valid_i = 1'b1; wb_inta_i = 1'b1; wb_ack_i = 1'b1;
    repeat (3) tick();
    check("reset_ctrl", {cmd_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o, irq_o, irq_rise_o}, 7'b0);
    check("reset_data", {wb_adr_o, wb_sel_o, rsp_status_o}, 14'b0);
    check("reset_wdat", wb_dat_o, 0);
    check("reset_rdat", rsp_dat_o, 0);
    check("reset_state", dbg_state, ST_IDLE);
    cmd_valid_i = 1'b0; wb_inta_i = 1'b0; wb_ack_i = 1'b0;
    wb_rst_i = 1'b1;
    tick();
    check("ready_after_reset", {cmd_ready_o, rsp_valid_o}, 2'b10);

    // Stray ack/err while idle must not produce anything.
    wb_ack_i = 1'b1; wb_err_i = 1'b1;
    tick();
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    tick();
    check("idle_ack_ignored", {rsp_valid_o, wb_cyc_o, cmd_ready_o}, 3'b001);

    // Table-driven transactions.
    for (int i = 0; i < 7; i++) begin
      send_cmd(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].exp_st, vecs[i].exp_dat, 1'b1);
      bus_respond(vecs[i].waits, vecs[i].ack, vecs[i].err, vecs[i].rdata,
                  vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel);
      collect_rsp();
    end

    // Random transactions; expectation from the response rules.
    for (int i = 0; i < 8; i++) begin
      logic        we;
      logic [7:0]  adr;
      logic [31:0] dat, rd;
      logic [3:0]  sel;
      int          waits, mode;
      we = 1'($urandom_range(0, 1)); adr = 8'($urandom); dat = $urandom; rd = $urandom;
      sel = 4'($urandom_range(1, 15)); waits = $urandom_range(0, 3); mode = $urandom_range(0, 2);
      send_cmd(we, adr, dat, sel, (mode == 0) ? RSP_OK : RSP_ERR,
               (mode == 0 && !we) ? rd : 32'h0, 1'b1);
      bus_respond(waits, mode != 1, mode != 0, rd, we, adr, dat, sel);
      collect_rsp();
    end

    // Error with simultaneous ack; response held while consumer stalls.
    send_cmd(1'b0, 8'h08, 32'h0, 4'hF, RSP_ERR, 32'h0, 1'b1);
    bus_respond(0, 1'b1, 1'b1, 32'h0BAD_F00D, 1'b0, 8'h08, 32'h0, 4'hF);
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("err_hold", {rsp_valid_o, rsp_status_o, rsp_dat_o, cmd_ready_o, wb_cyc_o},
            {1'b1, RSP_ERR, 32'h0, 1'b0, 1'b0});
      wb_ack_i = 1'($urandom_range(0, 1)); wb_err_i = 1'($urandom_range(0, 1)); wb_dat_i = $urandom;
      tick();
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    collect_rsp();   // checks no command was taken in the release cycle
    cmd_valid_i = 1'b0;
    tick();
    check("no_cmd_after_release", wb_cyc_o, 0);

    // Slave never answers.
`ifdef WB_GPIO_MASTER_TIMEOUT_EN
    begin
      int n = 0;
      wb_dat_i = 32'h7777_7777;
      send_cmd(1'b0, 8'h30, 32'h0, 4'hF, RSP_TIMEOUT, 32'h0, 1'b1);
      while (wb_cyc_o && n < 300) begin n++; tick(); end
      check("timeout_cycles", n, TO_CYC);
      collect_rsp();
    end
`else
    begin
      int n = 0;
      send_cmd(1'b0, 8'h30, 32'h0, 4'hF, RSP_OK, 32'h7E57_0001, 1'b1);
      for (int i = 0; i < 100; i++) begin
        if (wb_cyc_o && !rsp_valid_o) n++;
        tick();
      end
      check("no_timeout_hold", n, 100);
      wb_ack_i = 1'b1; wb_dat_i = 32'h7E57_0001;
      tick();
      wb_ack_i = 1'b0;
      collect_rsp();
    end
`endif

    // Reset in the middle of a bus cycle.
    begin
      bit seen = 1'b0;
      send_cmd(1'b1, 8'h40, 32'h1357_9BDF, 4'hF, RSP_OK, 32'h0, 1'b0);
      tick();
      wb_rst_i = 1'b0;
      tick();
      check("midrst_cyc", {wb_cyc_o, wb_stb_o, rsp_valid_o}, 3'b000);
      wb_rst_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (rsp_valid_o) seen = 1'b1;
        tick();
      end
      check("midrst_no_rsp", seen, 0);
      check("midrst_ready", {cmd_ready_o, wb_cyc_o}, 2'b10);
    end

    // Interrupt: input high for 4 cycles.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) wb_inta_i = 1'b1;
      if (i == 4) wb_inta_i = 1'b0;
      #1;
      check("irq_o", irq_o, (i >= 1 && i <= 4));
      check("irq_rise", irq_rise_o, (i == 0));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
